alu_issue: RTL and testbench
============================

# alu_issue

Sequential front end for the combinational `alu`: accepts one RV32I OP/OP-IMM arithmetic instruction per handshake, decodes `funct3`/`funct7[5]`/immediate selection into an `alu_control_t` code, and selects operand B. It drives a single `alu` instance and holds the result in an output register until the consumer accepts it. This is the control-producing end of the ALU interface and sits between the register-read stage and writeback.

## Interface
- `N`, 32: datapath width. Only 32 is supported.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `i_valid` input 1: the instruction fields are valid.
- `i_ready` output 1: the block can accept an instruction this cycle.
- `i_funct3` input 3: RV32I `funct3`.
- `i_funct7_5` input 1: instruction bit 30.
- `i_is_imm` input 1: 1 means OP-IMM, 0 means OP.
- `i_rs1` input N: operand A.
- `i_rs2` input N: register operand B.
- `i_imm` input N: sign-extended I-immediate.
- `o_valid` output 1: result register is full.
- `o_ready` input 1: the consumer accepts the result.
- `o_result` output N: registered ALU result.
- `o_illegal` output 1: the registered instruction was an illegal encoding.
- `o_count` output 16: saturating count of accepted legal instructions.

## Operation
- Decode rules by `funct3`:
  - 000: ADD, or SUB when `!i_is_imm & i_funct7_5`.
  - 001: SLL.
  - 010: SLT.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when `i_funct7_5`.
  - 110: OR.
  - 111: AND.
- Illegal encodings:
  - OP with `i_funct7_5=1` and `funct3` not in {000, 101}.
  - OP-IMM with `funct3=001` and `i_funct7_5=1`.
- Operand B selection:
  - OP: `i_rs2`.
  - OP-IMM shifts (001/101): `{27'b0, i_imm[4:0]}`.
  - Other OP-IMM: `i_imm`.
- For illegal encodings, the decoded code is the 0000 no-op. The ALU then outputs 0, so the registered result is 0 and `o_illegal=1`.
- SLT and SLTU results are zero-extended to N bits (bit 0 = comparison result).
- FSM with two states:
  - EMPTY: `o_valid=0`.
  - FULL: `o_valid=1`.
- Transitions:
  - EMPTY to FULL on `i_valid & i_ready`.
  - FULL to EMPTY on `o_ready & !(i_valid)`.
  - FULL stays FULL, with the registers reloaded, on `o_ready & i_valid` (back-to-back).
  - FULL stays FULL, with the registers held, on `!o_ready`.
- `i_ready = (state==EMPTY) | o_ready`. This is combinational from `o_ready`; there is no bubble on back-to-back traffic.
- `o_count` increments by 1 on each accepted legal instruction and saturates at 16'hFFFF. Illegal instructions do not count.

## Timing
- Reset (asynchronous assert, any cycle): state = EMPTY, `o_valid=0`, `o_result=0`, `o_illegal=0`, `o_count=0`. An in-flight result is discarded.
- Latency: acceptance edge to `o_valid`/`o_result` valid is 1 cycle. The ALU and decode are combinational in the cycle of acceptance.
- While `o_valid & !o_ready`: `o_result` and `o_illegal` are stable and `i_ready=0`.
- Input fields are sampled only on the `i_valid & i_ready` edge. Input values in other cycles are ignored.
- Simultaneous acceptance at both ports in FULL: the old result is consumed and the new one is loaded on the same edge.
- `o_count` at 16'hFFFF with a further legal acceptance: the count stays 16'hFFFF.

## Structure
- Already in `alu_types.sv`: the `alu_control_t` codes ALU_AND=0001, ALU_OR=0010, ALU_XOR=0011, ALU_SLL=0101, ALU_SRL=0110, ALU_SRA=0111, ALU_ADD=1000, ALU_SUB=1100, ALU_SLT=1101, ALU_SLTU=1111.
- Added to `alu_types.sv`: `funct3_t` enum for the eight `funct3` values and `issue_state_t` {S_EMPTY, S_FULL}.
- Sub-module: `alu_decoder`, purely combinational. It maps (`funct3`, `funct7_5`, `is_imm`) to (`alu_control_t`, `illegal`, `b_sel`).
- The top instantiates `alu_decoder`, one `alu`, the operand-B mux, the FSM, and the output and count registers.

## Test plan
- Reset mid-FULL. Stimulus: hold `o_ready=0` after one accepted instruction, then pulse `rst` low. Required: immediately after reset, `o_valid=0`, `o_result=0`, `o_count=0`, and `i_ready=1`.
- OP SUB. Stimulus: `funct3=000`, `funct7_5=1`, `rs1=5`, `rs2=7`. Required: one cycle later, `o_result=32'hFFFFFFFE` and `o_illegal=0`.
- OP-IMM SRAI. Stimulus: `funct3=101`, `funct7_5=1`, `rs1=32'h80000000`, `imm=32'h00000404`. Required: `o_result=32'hF8000000` (shift by 4, using `imm[4:0]`).
- SLT vs SLTU. Stimulus: `rs1=32'hFFFFFFFF`, `rs2=1`. Required: SLT gives `o_result=1` and SLTU gives `o_result=0`.
- Illegal encoding. Stimulus: OP with `funct3=111` and `funct7_5=1`. Required: `o_illegal=1`, `o_result=0`, and `o_count` unchanged.
- Backpressure and streaming.
  - Hold `o_ready=0` for 3 cycles with `i_valid=1`. Required: `i_ready=0` and `o_result` stable throughout.
  - Then stream 4 ADDs with `o_ready=1`. Required: 4 results on consecutive cycles and `o_count` up by 4.
  - Preload the count to 16'hFFFF and accept one more legal instruction. Required: `o_count` stays 16'hFFFF.

Source files
------------

// File: rtl/alu_types.sv
// Shared types for the ALU and its issue front end.
package alu_types;

    // ALU operation codes; 0000 is the no-op that yields zero.
    typedef enum logic [3:0] {
        ALU_NOP  = 4'b0000,
        ALU_AND  = 4'b0001,
        ALU_OR   = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_ADD  = 4'b1000,
        ALU_SUB  = 4'b1100,
        ALU_SLT  = 4'b1101,
        ALU_SLTU = 4'b1111
    } alu_control_t;

    // RV32I OP/OP-IMM funct3 values.
    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } funct3_t;

    // Result register occupancy.
    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } issue_state_t;

    // Operand B source.
    typedef enum logic [1:0] {
        B_RS2   = 2'd0,
        B_IMM   = 2'd1,
        B_SHAMT = 2'd2
    } b_sel_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU driven by an alu_control_t code.
module alu
    import alu_types::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  alu_control_t  control,
    output logic [N-1:0]  result
);

    localparam int unsigned SW = $clog2(N);

    logic [SW-1:0] shamt;
    assign shamt = b[SW-1:0];

    // Operation select; unknown codes and the no-op produce zero.
    always_comb begin
        result = '0;
        case (control)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(N-1){1'b0}}, (a < b)};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_decoder.sv
// Maps funct3/funct7[5]/OP-IMM to an ALU code, illegal flag and operand-B source.
module alu_decoder
    import alu_types::*;
(
    input  logic [2:0]    funct3,
    input  logic          funct7_5,
    input  logic          is_imm,
    output alu_control_t  control,
    output logic          illegal,
    output b_sel_t        b_sel
);

    funct3_t f3;
    assign f3 = funct3_t'(funct3);

    // Decode; an illegal encoding forces the no-op so the ALU returns zero.
    always_comb begin
        control = ALU_NOP;
        illegal = 1'b0;
        b_sel   = is_imm ? B_IMM : B_RS2;
        unique case (f3)
            F3_ADD:  control = (!is_imm && funct7_5) ? ALU_SUB : ALU_ADD;
            F3_SLL:  control = ALU_SLL;
            F3_SLT:  control = ALU_SLT;
            F3_SLTU: control = ALU_SLTU;
            F3_XOR:  control = ALU_XOR;
            F3_SR:   control = funct7_5 ? ALU_SRA : ALU_SRL;
            F3_OR:   control = ALU_OR;
            F3_AND:  control = ALU_AND;
        endcase
        // Immediate shifts take only the low five immediate bits.
        if (is_imm && (f3 == F3_SLL || f3 == F3_SR)) begin
            b_sel = B_SHAMT;
        end
        // For OP-IMM non-shifts bit 30 is just immediate data.
        if ((!is_imm && funct7_5 && f3 != F3_ADD && f3 != F3_SR) ||
            (is_imm && funct7_5 && f3 == F3_SLL)) begin
            illegal = 1'b1;
            control = ALU_NOP;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Single-entry issue stage: decode, ALU, registered result with valid/ready.
module alu_issue
    import alu_types::*;
#(
    parameter int unsigned N = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [2:0]    i_funct3,
    input  logic          i_funct7_5,
    input  logic          i_is_imm,
    input  logic [N-1:0]  i_rs1,
    input  logic [N-1:0]  i_rs2,
    input  logic [N-1:0]  i_imm,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [N-1:0]  o_result,
    output logic          o_illegal,
    output logic [15:0]   o_count
);

    issue_state_t  state_q;
    logic [N-1:0]  result_q;
    logic          illegal_q;
    logic [15:0]   count_q;

    alu_control_t  control;
    logic          illegal;
    b_sel_t        b_sel;
    logic [N-1:0]  op_b;
    logic [N-1:0]  alu_result;
    logic          accept;

    // Ready is combinational from o_ready so a full register can stream.
    assign i_ready = (state_q == S_EMPTY) | o_ready;
    assign accept  = i_valid & i_ready;

    alu_decoder u_decoder (
        .funct3   (i_funct3),
        .funct7_5 (i_funct7_5),
        .is_imm   (i_is_imm),
        .control  (control),
        .illegal  (illegal),
        .b_sel    (b_sel)
    );

    // Operand-B source select.
    always_comb begin
        op_b = i_rs2;
        case (b_sel)
            B_RS2:   op_b = i_rs2;
            B_IMM:   op_b = i_imm;
            B_SHAMT: op_b = {{(N-5){1'b0}}, i_imm[4:0]};
            default: op_b = i_rs2;
        endcase
    end

    alu #(
        .N (N)
    ) u_alu (
        .a       (i_rs1),
        .b       (op_b),
        .control (control),
        .result  (alu_result)
    );

    // Occupancy FSM with the result/illegal registers loaded on acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_EMPTY;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                state_q   <= S_FULL;
                result_q  <= alu_result;
                illegal_q <= illegal;
            end else if (state_q == S_FULL && o_ready) begin
                state_q <= S_EMPTY;
            end
        end
    end

    // Saturating count of accepted legal instructions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (accept && !illegal && count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign o_valid   = (state_q == S_FULL);
    assign o_result  = result_q;
    assign o_illegal = illegal_q;
    assign o_count   = count_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [2:0]  i_funct3;
    logic        i_funct7_5;
    logic        i_is_imm;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic [31:0] i_imm;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_result;
    logic        o_illegal;
    logic [15:0] o_count;

    typedef struct packed {
        logic        il;
        logic [31:0] res;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [15:0] exp_count = 16'd0;

    alu_issue #(.N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .i_funct3   (i_funct3),
        .i_funct7_5 (i_funct7_5),
        .i_is_imm   (i_is_imm),
        .i_rs1      (i_rs1),
        .i_rs2      (i_rs2),
        .i_imm      (i_imm),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_result   (o_result),
        .o_illegal  (o_illegal),
        .o_count    (o_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour written straight from the RV32I semantics.
    function automatic exp_t model(input logic [2:0] f3, input logic f7, input logic imm_op,
                                   input logic [31:0] a, input logic [31:0] r2,
                                   input logic [31:0] imm);
        exp_t        e;
        logic [31:0] b;
        e.il = (!imm_op && f7 && f3 != 3'd0 && f3 != 3'd5) || (imm_op && f3 == 3'd1 && f7);
        if (!imm_op)                     b = r2;
        else if (f3 == 3'd1 || f3 == 3'd5) b = {27'b0, imm[4:0]};
        else                             b = imm;
        case (f3)
            3'd0:    e.res = (!imm_op && f7) ? a - b : a + b;
            3'd1:    e.res = a << b[4:0];
            3'd2:    e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    e.res = (a < b) ? 32'd1 : 32'd0;
            3'd4:    e.res = a ^ b;
            3'd5:    e.res = f7 ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    e.res = a | b;
            default: e.res = a & b;
        endcase
        if (e.il) e.res = 32'd0;
        return e;
    endfunction

    // Drive one instruction and hold it until accepted (bounded wait).
    task automatic send(input logic [2:0] f3, input logic f7, input logic imm_op,
                        input logic [31:0] a, input logic [31:0] r2, input logic [31:0] imm,
                        output int acc_cyc);
        logic acc_now;
        logic accepted;
        exp_t e;
        i_valid    = 1'b1;
        i_funct3   = f3;
        i_funct7_5 = f7;
        i_is_imm   = imm_op;
        i_rs1      = a;
        i_rs2      = r2;
        i_imm      = imm;
        accepted   = 1'b0;
        acc_cyc    = -1;
        for (int k = 0; k < 20 && !accepted; k++) begin
            @(negedge clk);
            acc_now = i_ready;
            @(posedge clk);
            if (acc_now) accepted = 1'b1;
        end
        if (!accepted) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            e = model(f3, f7, imm_op, a, r2, imm);
            sb.push_back(e);
            if (!e.il && exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
        end
        #1;
        acc_cyc = cyc;
        check("latency_valid", {31'b0, o_valid}, 32'd1);
        i_valid = 1'b0;
    endtask

    // Pop and compare on every cycle in which a result is consumed.
    always @(negedge clk) begin
        if (rst && o_valid && o_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", o_result, e.res);
                check("illegal", {31'b0, o_illegal}, {31'b0, e.il});
            end
        end
    end

    int          c0;
    int          c1;
    int          ctmp;
    logic [31:0] held;

    initial begin
        rst        = 1'b0;
        i_valid    = 1'b0;
        o_ready    = 1'b0;
        i_funct3   = 3'd0;
        i_funct7_5 = 1'b0;
        i_is_imm   = 1'b0;
        i_rs1      = 32'd0;
        i_rs2      = 32'd0;
        i_imm      = 32'd0;
        #1;
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_illegal", {31'b0, o_illegal}, 32'd0);
        check("rst_count", {16'b0, o_count}, 32'd0);
        check("rst_iready", {31'b0, i_ready}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;

        // Reset while a result is held.
        send(3'd0, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, ctmp);
        @(posedge clk);
        #1;
        check("full_held", {31'b0, o_valid}, 32'd1);
        check("full_count", {16'b0, o_count}, 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_valid", {31'b0, o_valid}, 32'd0);
        check("midrst_result", o_result, 32'd0);
        check("midrst_count", {16'b0, o_count}, 32'd0);
        check("midrst_iready", {31'b0, i_ready}, 32'd1);
        sb.delete();
        exp_count = 16'd0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed operations with the consumer always ready.
        o_ready = 1'b1;
        send(3'd0, 1'b1, 1'b0, 32'd5, 32'd7, 32'd0, ctmp);                    // SUB
        send(3'd5, 1'b1, 1'b1, 32'h80000000, 32'd0, 32'h00000404, ctmp);      // SRAI
        send(3'd2, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, ctmp);             // SLT
        send(3'd3, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, ctmp);             // SLTU
        send(3'd5, 1'b0, 1'b1, 32'h80000000, 32'd0, 32'hFFFFFFE3, ctmp);      // SRLI by 3
        send(3'd1, 1'b0, 1'b0, 32'h00000003, 32'h00000024, 32'd0, ctmp);      // SLL by 4
        send(3'd0, 1'b1, 1'b1, 32'd10, 32'd0, 32'hFFFFF800, ctmp);            // ADDI, bit30 set
        send(3'd4, 1'b0, 1'b1, 32'hA5A5A5A5, 32'd0, 32'hFFFFFFFF, ctmp);      // XORI
        send(3'd6, 1'b0, 1'b0, 32'hF0F00000, 32'h00000F0F, 32'd0, ctmp);      // OR
        send(3'd7, 1'b0, 1'b1, 32'h12345678, 32'd0, 32'h000000FF, ctmp);      // ANDI
        send(3'd2, 1'b0, 1'b1, 32'd3, 32'd0, 32'hFFFFFFFF, ctmp);             // SLTI 3 < -1
        @(posedge clk);
        #1;
        check("cnt_legal", {16'b0, o_count}, {16'b0, exp_count});

        // Illegal encodings leave the count untouched.
        send(3'd7, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, ctmp);      // OP AND f7=1
        send(3'd1, 1'b1, 1'b1, 32'd1, 32'd0, 32'h00000401, ctmp);             // SLLI f7=1
        @(posedge clk);
        #1;
        check("cnt_illegal", {16'b0, o_count}, {16'b0, exp_count});

        // Backpressure: result held, input refused.
        o_ready = 1'b0;
        send(3'd0, 1'b0, 1'b0, 32'd100, 32'd23, 32'd0, ctmp);
        held       = 32'd123;
        i_valid    = 1'b1;
        i_funct3   = 3'd4;
        i_rs1      = 32'hDEADBEEF;
        i_rs2      = 32'h0000FFFF;
        for (int k = 0; k < 3; k++) begin
            check("bp_iready", {31'b0, i_ready}, 32'd0);
            check("bp_result", o_result, held);
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        @(posedge clk);
        #1;

        // Four back-to-back ADDs.
        begin
            logic [15:0] cnt0;
            cnt0 = o_count;
            send(3'd0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, c0);
            send(3'd0, 1'b0, 1'b0, 32'd2, 32'd2, 32'd0, ctmp);
            send(3'd0, 1'b0, 1'b0, 32'd3, 32'd3, 32'd0, ctmp);
            send(3'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2, 32'd0, c1);
            check("stream_cycles", 32'(c1 - c0), 32'd3);
            check("stream_count", {16'b0, o_count}, {16'b0, cnt0 + 16'd4});
        end

        // Drive the count up to saturation, then one more.
        while (exp_count != 16'hFFFF) begin
            send(3'd0, 1'b0, 1'b1, 32'(cyc), 32'd0, 32'd1, ctmp);
        end
        @(posedge clk);
        #1;
        check("sat_reach", {16'b0, o_count}, 32'h0000FFFF);
        send(3'd6, 1'b0, 1'b0, 32'h1, 32'h2, 32'd0, ctmp);
        @(posedge clk);
        #1;
        check("sat_hold", {16'b0, o_count}, 32'h0000FFFF);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        check("end_valid", {31'b0, o_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
